// File: rtl/axi_sram_pkg.sv
// Shared types and AXI encodings for the SRAM responder and its bank.
// beat_step gives the per-beat address increment, capping size at the bus width.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WRESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // WRAP advances like INCR; the reserved encoding does the same.
  function automatic logic [7:0] beat_step(input logic [1:0] burst,
                                           input logic [2:0] size,
                                           input logic [2:0] max_size);
    logic [2:0] eff;
    eff = (size > max_size) ? max_size : size;
    case (burst)
      AXI_BURST_FIXED:                beat_step = 8'd0;
      AXI_BURST_INCR, AXI_BURST_WRAP: beat_step = 8'd1 << eff;
      default:                        beat_step = 8'd1 << eff;
    endcase
  endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI4 signal bundle covering AR/R/AW/W/B, with responder and requester views.
// The responder ties all five channels to one SRAM bank.
interface axi_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_sram_bank.sv
// Single-port byte-enabled SRAM with a synchronous read register that holds
// its value whenever rd_en is low; contents are never reset.
module axi_sram_bank #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int BE_W        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [BE_W-1:0]       wr_be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rd_en) rdata_q <= mem[idx];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 responder in front of one SRAM bank, one burst in flight at a time.
// The R channel is a one-deep pipeline: the bank read register is the R data holding stage.
module axi_sram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 6,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic         clk,
  input logic         rst,
  axi_interface.slave axi
);
  import axi_sram_pkg::*;

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] MAX_SIZE = 3'(SHIFT);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    in_range = !off[ADDR_WIDTH] && ((off[ADDR_WIDTH-1:0] >> (SHIFT + IDX_W)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    word_idx = IDX_W'((a - BASE_ADDR) >> SHIFT);
  endfunction

  state_e                state_q, state_d;
  logic                  prio_rd_q, prio_rd_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, beat_q, beat_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d, rresp_q, rresp_d, bresp_q, bresp_d;
  logic                  err_q, err_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                  wready_q, wready_d, bvalid_q, bvalid_d;

  logic                  arready_c, awready_c, ar_hs, aw_hs, rd_issue, wr_beat;
  logic                  wr_at_len, wr_last, wr_err;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            step_ar, step_q;
  logic [BE_W-1:0]       sram_be;
  logic [IDX_W-1:0]      sram_idx;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Reset also masks the handshakes so nothing is accepted while rst is held.
  assign arready_c = (state_q == ST_IDLE) && !rst && axi.arvalid && (!axi.awvalid || prio_rd_q);
  assign awready_c = (state_q == ST_IDLE) && !rst && axi.awvalid && (!axi.arvalid || !prio_rd_q);
  assign ar_hs     = arready_c;
  assign aw_hs     = awready_c;
  assign step_ar   = beat_step(axi.arburst, axi.arsize, MAX_SIZE);
  assign step_q    = beat_step(burst_q, size_q, MAX_SIZE);

  // Beat 0 is read in the AR handshake cycle; later beats only as the current one is taken.
  assign rd_issue  = ar_hs || ((state_q == ST_READ) && axi.rready && !rlast_q);
  assign rd_addr   = ar_hs ? axi.araddr : addr_q;
  assign wr_beat   = (state_q == ST_WRITE) && axi.wvalid;
  assign wr_at_len = (beat_q == len_q);
  assign wr_last   = axi.wlast || wr_at_len;
  assign wr_err    = err_q || !in_range(addr_q) || (axi.wlast != wr_at_len);
  assign sram_be   = (wr_beat && in_range(addr_q)) ? axi.wstrb : '0;
  assign sram_idx  = word_idx(wr_beat ? addr_q : rd_addr);

  axi_sram_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .rd_en (rd_issue),
    .wr_be (sram_be),
    .idx   (sram_idx),
    .wdata (axi.wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          id_d      = axi.arid;
          len_d     = axi.arlen;
          size_d    = axi.arsize;
          burst_d   = axi.arburst;
          addr_d    = axi.araddr + ADDR_WIDTH'(step_ar);
          beat_d    = 8'd1;
          rvalid_d  = 1'b1;
          rlast_d   = (axi.arlen == 8'd0);
          rresp_d   = in_range(axi.araddr) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          prio_rd_d = !prio_rd_q;
          state_d   = ST_READ;
        end else if (aw_hs) begin
          id_d      = axi.awid;
          len_d     = axi.awlen;
          size_d    = axi.awsize;
          burst_d   = axi.awburst;
          addr_d    = axi.awaddr;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          wready_d  = 1'b1;
          prio_rd_d = !prio_rd_q;
          state_d   = ST_WRITE;
        end
      end
      ST_READ: begin
        if (axi.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            rlast_d  = (beat_q == len_q);
            rresp_d  = in_range(addr_q) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            addr_d   = addr_q + ADDR_WIDTH'(step_q);
            beat_d   = beat_q + 8'd1;
          end
        end
      end
      ST_WRITE: begin
        if (axi.wvalid) begin
          err_d = wr_err;
          if (wr_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            state_d  = ST_WRESP;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(step_q);
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_WRESP: begin
        if (axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign axi.arready = arready_c;
  assign axi.awready = awready_c;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = id_q;
  assign axi.rdata   = (rvalid_q && (rresp_q == AXI_RESP_OKAY)) ? sram_rdata : '0;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bid     = id_q;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: bursts, backpressure, arbitration,
// out-of-range handling and mid-burst reset, with hand-computed expectations.
module tb_axi_sram_responder;
  import axi_sram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6)) axi_if ();

  axi_sram_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_send(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [5:0] id);
    logic ok;
    logic rv_pre;
    axi_if.araddr  = addr;
    axi_if.arlen   = len;
    axi_if.arsize  = 3'd2;
    axi_if.arburst = AXI_BURST_INCR;
    axi_if.arid    = id;
    axi_if.arvalid = 1'b1;
    ok = 1'b0;
    rv_pre = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = axi_if.arready;
      rv_pre = axi_if.rvalid;
      @(posedge clk);
      #1;
    end
    axi_if.arvalid = 1'b0;
    check_eq({tag, "_ar_hs"}, ok, 1);
    check_eq({tag, "_rvalid_N"}, rv_pre, 0);
    check_eq({tag, "_rvalid_N1"}, axi_if.rvalid, 1);
  endtask

  task automatic r_beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [5:0] id, input int stall);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi_if.rvalid) ok = 1'b1;
      else tick();
    end
    check_eq({tag, "_rvalid"}, ok, 1);
    for (int s = 0; s < stall; s++) begin
      axi_if.rready = 1'b0;
      tick();
      check_eq({tag, "_hold_rvalid"}, axi_if.rvalid, 1);
      check_eq({tag, "_hold_rdata"}, axi_if.rdata, d);
      check_eq({tag, "_hold_rlast"}, axi_if.rlast, last);
    end
    axi_if.rready = 1'b1;
    check_eq({tag, "_rdata"}, axi_if.rdata, d);
    check_eq({tag, "_rresp"}, axi_if.rresp, resp);
    check_eq({tag, "_rlast"}, axi_if.rlast, last);
    check_eq({tag, "_rid"}, axi_if.rid, id);
    tick();
  endtask

  task automatic aw_send(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [5:0] id);
    logic ok;
    axi_if.awaddr  = addr;
    axi_if.awlen   = len;
    axi_if.awsize  = 3'd2;
    axi_if.awburst = AXI_BURST_INCR;
    axi_if.awid    = id;
    axi_if.awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = axi_if.awready;
      @(posedge clk);
      #1;
    end
    axi_if.awvalid = 1'b0;
    check_eq({tag, "_aw_hs"}, ok, 1);
  endtask

  task automatic w_beat(input string tag, input logic [31:0] d, input logic [3:0] strb,
                        input logic last);
    logic ok;
    axi_if.wdata  = d;
    axi_if.wstrb  = strb;
    axi_if.wlast  = last;
    axi_if.wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = axi_if.wready;
      @(posedge clk);
      #1;
    end
    axi_if.wvalid = 1'b0;
    axi_if.wlast  = 1'b0;
    if (!ok) check_eq({tag, "_w_timeout"}, ok, 1);
  endtask

  task automatic b_resp(input string tag, input logic [1:0] resp, input logic [5:0] id);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (axi_if.bvalid) begin
        ok = 1'b1;
        check_eq({tag, "_bresp"}, axi_if.bresp, resp);
        check_eq({tag, "_bid"}, axi_if.bid, id);
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_bvalid"}, ok, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    axi_if.arvalid = 1'b1; axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b0;
    axi_if.rready = 1'b1;  axi_if.bready = 1'b1;  axi_if.wlast = 1'b0;
    axi_if.araddr = '0; axi_if.arlen = '0; axi_if.arsize = 3'd2; axi_if.arburst = AXI_BURST_INCR; axi_if.arid = '0;
    axi_if.awaddr = '0; axi_if.awlen = '0; axi_if.awsize = 3'd2; axi_if.awburst = AXI_BURST_INCR; axi_if.awid = '0;
    axi_if.wdata = '0; axi_if.wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_arready", axi_if.arready, 0);
    check_eq("rst_awready", axi_if.awready, 0);
    check_eq("rst_rvalid", axi_if.rvalid, 0);
    check_eq("rst_wready", axi_if.wready, 0);
    check_eq("rst_bvalid", axi_if.bvalid, 0);
    check_eq("rst_rlast", axi_if.rlast, 0);
    check_eq("rst_rresp", axi_if.rresp, 0);
    check_eq("rst_bresp", axi_if.bresp, 0);
    check_eq("rst_rid", axi_if.rid, 0);
    check_eq("rst_bid", axi_if.bid, 0);
    check_eq("rst_rdata", axi_if.rdata, 0);
    axi_if.arvalid = 1'b0;
    axi_if.awvalid = 1'b0;
    rst = 1'b0;
    tick();

    // Prefill words 0..3
    aw_send("pre", 32'h0, 8'd3, 6'h01);
    w_beat("pre0", 32'h11, 4'hF, 1'b0);
    w_beat("pre1", 32'h22, 4'hF, 1'b0);
    w_beat("pre2", 32'h33, 4'hF, 1'b0);
    w_beat("pre3", 32'h44, 4'hF, 1'b1);
    b_resp("pre", AXI_RESP_OKAY, 6'h01);

    // Four-beat INCR read
    ar_send("rd4", 32'h0, 8'd3, 6'h0A);
    r_beat("rd4_b0", 32'h11, AXI_RESP_OKAY, 1'b0, 6'h0A, 0);
    r_beat("rd4_b1", 32'h22, AXI_RESP_OKAY, 1'b0, 6'h0A, 0);
    r_beat("rd4_b2", 32'h33, AXI_RESP_OKAY, 1'b0, 6'h0A, 0);
    r_beat("rd4_b3", 32'h44, AXI_RESP_OKAY, 1'b1, 6'h0A, 0);
    check_eq("rd4_done_rvalid", axi_if.rvalid, 0);

    // Same read with backpressure on beats 1 and 2
    ar_send("rds", 32'h0, 8'd3, 6'h0B);
    r_beat("rds_b0", 32'h11, AXI_RESP_OKAY, 1'b0, 6'h0B, 0);
    r_beat("rds_b1", 32'h22, AXI_RESP_OKAY, 1'b0, 6'h0B, 3);
    r_beat("rds_b2", 32'h33, AXI_RESP_OKAY, 1'b0, 6'h0B, 3);
    r_beat("rds_b3", 32'h44, AXI_RESP_OKAY, 1'b1, 6'h0B, 0);
    check_eq("rds_done_rvalid", axi_if.rvalid, 0);

    // Partial-strobe write to words 2 and 3
    aw_send("wh", 32'h8, 8'd1, 6'h15);
    w_beat("wh0", 32'hAAAA_BBBB, 4'h3, 1'b0);
    w_beat("wh1", 32'hCCCC_DDDD, 4'hC, 1'b1);
    b_resp("wh", AXI_RESP_OKAY, 6'h15);
    ar_send("rh", 32'h8, 8'd1, 6'h16);
    r_beat("rh_b0", 32'h0000_BBBB, AXI_RESP_OKAY, 1'b0, 6'h16, 0);
    r_beat("rh_b1", 32'hCCCC_0044, AXI_RESP_OKAY, 1'b1, 6'h16, 0);

    // Arbitration: read wins first after reset, then alternate
    pulse_rst();
    axi_if.araddr = 32'h0;  axi_if.arlen = 8'd0; axi_if.arid = 6'h12; axi_if.arvalid = 1'b1;
    axi_if.awaddr = 32'h10; axi_if.awlen = 8'd0; axi_if.awid = 6'h13; axi_if.awvalid = 1'b1;
    #1;
    check_eq("c1_arready", axi_if.arready, 1);
    check_eq("c1_awready", axi_if.awready, 0);
    @(posedge clk);
    #1;
    axi_if.arvalid = 1'b0;
    #1;
    check_eq("c1_awready_busy", axi_if.awready, 0);
    r_beat("c1_rd", 32'h11, AXI_RESP_OKAY, 1'b1, 6'h12, 0);
    aw_send("c1_aw", 32'h10, 8'd0, 6'h13);
    w_beat("c1_w", 32'h55, 4'hF, 1'b1);
    b_resp("c1", AXI_RESP_OKAY, 6'h13);
    axi_if.araddr = 32'h0;  axi_if.arlen = 8'd0; axi_if.arid = 6'h14; axi_if.arvalid = 1'b1;
    axi_if.awaddr = 32'h14; axi_if.awlen = 8'd0; axi_if.awid = 6'h15; axi_if.awvalid = 1'b1;
    #1;
    check_eq("c2_arready", axi_if.arready, 1);
    check_eq("c2_awready", axi_if.awready, 0);
    @(posedge clk);
    #1;
    axi_if.arvalid = 1'b0;
    r_beat("c2_rd", 32'h11, AXI_RESP_OKAY, 1'b1, 6'h14, 0);
    aw_send("c2_aw", 32'h14, 8'd0, 6'h15);
    w_beat("c2_w", 32'h66, 4'hF, 1'b1);
    b_resp("c2", AXI_RESP_OKAY, 6'h15);
    ar_send("c_chk", 32'h10, 8'd1, 6'h16);
    r_beat("c_chk_b0", 32'h55, AXI_RESP_OKAY, 1'b0, 6'h16, 0);
    r_beat("c_chk_b1", 32'h66, AXI_RESP_OKAY, 1'b1, 6'h16, 0);

    // Out-of-range read and early-wlast write
    ar_send("oor", 32'd4096, 8'd0, 6'h21);
    r_beat("oor_b0", 32'h0, AXI_RESP_SLVERR, 1'b1, 6'h21, 0);
    aw_send("early", 32'h20, 8'd2, 6'h22);
    w_beat("early0", 32'h77, 4'hF, 1'b0);
    w_beat("early1", 32'h88, 4'hF, 1'b1);
    check_eq("early_wready_off", axi_if.wready, 0);
    b_resp("early", AXI_RESP_SLVERR, 6'h22);

    // Reset in the middle of an 8-beat read
    aw_send("w8", 32'h40, 8'd7, 6'h30);
    for (int k = 0; k < 8; k++) w_beat("w8", 32'h100 + k, 4'hF, k == 7);
    b_resp("w8", AXI_RESP_OKAY, 6'h30);
    ar_send("r8", 32'h40, 8'd7, 6'h31);
    for (int k = 0; k < 4; k++) r_beat("r8", 32'h100 + k, AXI_RESP_OKAY, 1'b0, 6'h31, 0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rvalid_async", axi_if.rvalid, 0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_rvalid", axi_if.rvalid, 0);
    check_eq("mid_rst_rlast", axi_if.rlast, 0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("post_rst_rvalid", axi_if.rvalid, 0);
    check_eq("post_rst_bvalid", axi_if.bvalid, 0);
    ar_send("ra", 32'h44, 8'd1, 6'h32);
    r_beat("ra_b0", 32'h101, AXI_RESP_OKAY, 1'b0, 6'h32, 0);
    r_beat("ra_b1", 32'h102, AXI_RESP_OKAY, 1'b1, 6'h32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
